// File: rtl/softmax_pkg.sv
// softmax_pkg
//   Shared definitions for the softmax sequencing controller: the controller
//   state type, default vector geometry and the element-count width helper.
//   No ports; imported by softmax_seq_ctrl and softmax_elem_buf.
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam int DEF_N_ELEM = 8;
    localparam int DEF_ELEM_W = 3;

    // The element count must represent 0..n inclusive, so it needs one bit
    // more than an index into an n-entry buffer.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/softmax_elem_buf.sv
// softmax_elem_buf
//   N_ELEM x ELEM_W register buffer holding one vector while the datapath
//   computes its sum and reciprocal. One synchronous write port, one
//   combinational read port, no reset (contents are only read after being
//   written in the same vector).
//   Ports:
//     clk      - rising-edge clock
//     wr_en    - write strobe
//     wr_addr  - write index
//     wr_data  - element to store
//     rd_addr  - read index
//     rd_data  - element at rd_addr (combinational)
module softmax_elem_buf
    import softmax_pkg::*;
#(
    parameter int N_ELEM = DEF_N_ELEM,
    parameter int ELEM_W = DEF_ELEM_W,
    localparam int IDX_W = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [ELEM_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [ELEM_W-1:0] rd_data
);

    logic [ELEM_W-1:0] mem [N_ELEM];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Sequences one softmax vector at a time: elements stream into a buffer
//   while being accumulated by the datapath (LOAD), the controller waits for
//   the sum/reciprocal pipeline to settle (WAIT), then replays the buffered
//   elements to the subtractor array with a valid/ready handshake (EMIT).
//   Vectors never overlap: input is refused from WAIT until the last emit.
//   Optional feature: define SOFTMAX_CTRL_PERF_EN to add perf_vec_cnt, a
//   saturating 16-bit count of completed vectors.
//   Ports:
//     clk, rst           - clock, synchronous active-high reset
//     in_valid/in_ready  - input element handshake; in_data, in_last
//     dp_data            - element to the adder tree / subtractor array
//     dp_acc_clr         - accumulator loads instead of adds (first element)
//     dp_acc_en          - accumulator enable
//     out_valid/out_ready- emit handshake; out_idx, out_last
//     busy               - controller is not idle
//     perf_vec_cnt       - completed vectors (only with SOFTMAX_CTRL_PERF_EN)
//   DP_LAT must be at least 1.
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int N_ELEM = DEF_N_ELEM,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int DP_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_last,
    output logic [ELEM_W-1:0]         dp_data,
    output logic                      dp_acc_clr,
    output logic                      dp_acc_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(N_ELEM)-1:0] out_idx,
    output logic                      out_last,
    output logic                      busy
`ifdef SOFTMAX_CTRL_PERF_EN
    ,
    output logic [15:0]               perf_vec_cnt
`endif
);

    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int CNT_W  = cnt_width(N_ELEM);
    localparam int WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   idx_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_done;
    logic               accept;
    logic               handshake;
    logic               last_match;
    logic [IDX_W-1:0]   wr_addr;
    logic [ELEM_W-1:0]  rd_data;

    softmax_elem_buf #(
        .N_ELEM (N_ELEM),
        .ELEM_W (ELEM_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign wait_done  = (wait_cnt == WAIT_W'(DP_LAT - 1));
    assign last_match = ({1'b0, idx_q} == (count - CNT_W'(1)));

    // Next-state logic and input-side readiness.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_last ? WAIT : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || count == CNT_W'(N_ELEM - 1))) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready && last_match) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are masked while rst is high so a reset cycle never pulses
    // the accumulator or presents a result downstream.
    assign accept     = in_valid & in_ready & ~rst;
    assign dp_acc_en  = accept;
    assign dp_acc_clr = accept & (state == IDLE);
    assign out_valid  = (state == EMIT) & ~rst;
    assign out_last   = out_valid & last_match;
    assign handshake  = out_valid & out_ready;
    assign busy       = (state != IDLE);
    assign out_idx    = idx_q;
    // Pass the input straight through while loading so accumulation adds no
    // latency; otherwise replay from the buffer.
    assign dp_data    = in_ready ? in_data : rd_data;
    assign wr_addr    = (state == IDLE) ? '0 : count[IDX_W-1:0];

    // State register, element count, emit index and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            idx_q    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                count <= (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
            end
            if (state == WAIT) begin
                wait_cnt <= wait_done ? '0 : wait_cnt + WAIT_W'(1);
            end
            if (handshake) begin
                if (last_match) begin
                    idx_q <= '0;
                    count <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

`ifdef SOFTMAX_CTRL_PERF_EN
    logic [15:0] perf_cnt;

    // Completed-vector counter; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (handshake && last_match && perf_cnt != 16'hFFFF) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign perf_vec_cnt = perf_cnt;
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl
//   Directed bench for softmax_seq_ctrl (N_ELEM=8, ELEM_W=3, DP_LAT=2).
//   Per-cycle vector tables cover full-length and in_last-terminated vectors;
//   hand-written sequences cover output stall, single element and mid-emit
//   reset, plus the perf counter when SOFTMAX_CTRL_PERF_EN is defined.
module tb_softmax_seq_ctrl;

    localparam int N_ELEM = 8;
    localparam int ELEM_W = 3;
    localparam int DP_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;
    logic [ELEM_W-1:0] dp_data;
    logic              dp_acc_clr;
    logic              dp_acc_en;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              busy;
`ifdef SOFTMAX_CTRL_PERF_EN
    logic [15:0]       perf_vec_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    softmax_seq_ctrl #(
        .N_ELEM (N_ELEM),
        .ELEM_W (ELEM_W),
        .DP_LAT (DP_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .dp_data    (dp_data),
        .dp_acc_clr (dp_acc_clr),
        .dp_acc_en  (dp_acc_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
`ifdef SOFTMAX_CTRL_PERF_EN
        ,
        .perf_vec_cnt (perf_vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_valid;
        logic [2:0] in_data;
        logic       in_last;
        logic       out_ready;
        logic       e_in_ready;
        logic       e_acc_en;
        logic       e_acc_clr;
        logic       e_out_valid;
        logic       chk_data;
        logic [2:0] e_data;
        logic [2:0] e_idx;
        logic       e_out_last;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic iv, input logic [2:0] d, input logic il,
                                 input logic ordy, input logic ir, input logic en,
                                 input logic clr, input logic ov, input logic cd,
                                 input logic [2:0] ed, input logic [2:0] ei,
                                 input logic el, input logic b);
        vec_t v;
        v.in_valid = iv;   v.in_data = d;      v.in_last = il;    v.out_ready = ordy;
        v.e_in_ready = ir; v.e_acc_en = en;    v.e_acc_clr = clr; v.e_out_valid = ov;
        v.chk_data = cd;   v.e_data = ed;      v.e_idx = ei;      v.e_out_last = el;
        v.e_busy = b;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive inputs just after the falling edge and let them settle.
    task automatic applyInputs(input logic iv, input logic [2:0] d, input logic il,
                               input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        out_ready = ordy;
        #1;
    endtask

    task automatic applyStimulus(input int n, input vec_t v);
        applyInputs(v.in_valid, v.in_data, v.in_last, v.out_ready);
        checkOutput($sformatf("row%0d_in_ready", n), in_ready, v.e_in_ready);
        checkOutput($sformatf("row%0d_acc_en", n), dp_acc_en, v.e_acc_en);
        checkOutput($sformatf("row%0d_acc_clr", n), dp_acc_clr, v.e_acc_clr);
        checkOutput($sformatf("row%0d_out_valid", n), out_valid, v.e_out_valid);
        if (v.chk_data) begin
            checkOutput($sformatf("row%0d_dp_data", n), dp_data, v.e_data);
        end
        checkOutput($sformatf("row%0d_out_idx", n), out_idx, v.e_idx);
        checkOutput($sformatf("row%0d_out_last", n), out_last, v.e_out_last);
        checkOutput($sformatf("row%0d_busy", n), busy, v.e_busy);
    endtask

    task automatic checkEmit(input string name, input logic [2:0] d,
                             input logic [2:0] idx, input logic last);
        checkOutput({name, "_valid"}, out_valid, 1'b1);
        checkOutput({name, "_data"}, dp_data, d);
        checkOutput({name, "_idx"}, out_idx, idx);
        checkOutput({name, "_last"}, out_last, last);
    endtask

    // Idle cycles until the first emit is presented, bounded.
    task automatic waitOutValid(input string name);
        int n = 0;
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        while (out_valid !== 1'b1 && n < 10) begin
            applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
            n++;
        end
        checkOutput({name, "_reached_emit"}, out_valid, 1'b1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 3'd6; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_acc_en", dp_acc_en, 1'b0);
        checkOutput("reset_acc_clr", dp_acc_clr, 1'b0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_last", out_last, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_out_idx", out_idx, 3'd0);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Full-length vector 1..7,0 with no in_last: truncated at 8 elements.
        tbl.push_back(row(1, 3'd1, 0, 0,  1, 1, 1, 0,  1, 3'd1, 3'd0, 0, 0));
        for (int i = 2; i <= 8; i++) begin
            tbl.push_back(row(1, 3'(i % 8), 0, 0,  1, 1, 0, 0,  1, 3'(i % 8), 3'd0, 0, 1));
        end
        // WAIT: input offered but refused for exactly two cycles.
        tbl.push_back(row(1, 3'd5, 0, 0,  0, 0, 0, 0,  0, 3'd0, 3'd0, 0, 1));
        tbl.push_back(row(1, 3'd5, 0, 0,  0, 0, 0, 0,  0, 3'd0, 3'd0, 0, 1));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 1,  1, 3'((i + 1) % 8), 3'(i), (i == 7), 1));
        end
        tbl.push_back(row(0, 3'd0, 0, 0,  1, 0, 0, 0,  1, 3'd0, 3'd0, 0, 0));
        // Three elements 3,6,2 with a LOAD stall and in_last on the third.
        tbl.push_back(row(1, 3'd3, 0, 0,  1, 1, 1, 0,  1, 3'd3, 3'd0, 0, 0));
        tbl.push_back(row(0, 3'd0, 0, 0,  1, 0, 0, 0,  1, 3'd0, 3'd0, 0, 1));
        tbl.push_back(row(1, 3'd6, 0, 0,  1, 1, 0, 0,  1, 3'd6, 3'd0, 0, 1));
        tbl.push_back(row(1, 3'd2, 1, 0,  1, 1, 0, 0,  1, 3'd2, 3'd0, 0, 1));
        tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 0,  0, 3'd0, 3'd0, 0, 1));
        tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 0,  0, 3'd0, 3'd0, 0, 1));
        tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 1,  1, 3'd3, 3'd0, 0, 1));
        tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 1,  1, 3'd6, 3'd1, 0, 1));
        tbl.push_back(row(0, 3'd0, 0, 1,  0, 0, 0, 1,  1, 3'd2, 3'd2, 1, 1));
        tbl.push_back(row(0, 3'd0, 0, 0,  1, 0, 0, 0,  1, 3'd0, 3'd0, 0, 0));

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(i, tbl[i]);
        end

        // Output stall at idx 1 for five cycles.
        $display("[TB] output stall sequence");
        applyInputs(1'b1, 3'd4, 1'b0, 1'b0);
        applyInputs(1'b1, 3'd5, 1'b0, 1'b0);
        applyInputs(1'b1, 3'd6, 1'b1, 1'b0);
        waitOutValid("stall");
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("stall_e0", 3'd4, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
            checkEmit($sformatf("stall_hold%0d", i), 3'd5, 3'd1, 1'b0);
        end
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("stall_e1", 3'd5, 3'd1, 1'b0);
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("stall_e2", 3'd6, 3'd2, 1'b1);
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("stall_idle_in_ready", in_ready, 1'b1);
        checkOutput("stall_idle_busy", busy, 1'b0);

        // Single-element vector.
        $display("[TB] single element sequence");
        applyInputs(1'b1, 3'd5, 1'b1, 1'b0);
        checkOutput("single_acc_clr", dp_acc_clr, 1'b1);
        waitOutValid("single");
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("single_e0", 3'd5, 3'd0, 1'b1);
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("single_after_valid", out_valid, 1'b0);
        checkOutput("single_after_busy", busy, 1'b0);

        // Reset while emitting idx 4, then a fresh two-element vector.
        $display("[TB] mid-emit reset sequence");
        for (int i = 0; i < 8; i++) begin
            applyInputs(1'b1, 3'(7 - i), 1'b0, 1'b0);
        end
        waitOutValid("abort");
        for (int i = 0; i < 4; i++) begin
            applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
            checkEmit($sformatf("abort_e%0d", i), 3'(7 - i), 3'(i), 1'b0);
        end
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        checkEmit("abort_e4", 3'd3, 3'd4, 1'b0);
        rst = 1'b1;
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_in_ready", in_ready, 1'b1);
        checkOutput("abort_out_idx", out_idx, 3'd0);
        applyInputs(1'b1, 3'd3, 1'b0, 1'b0);
        checkOutput("abort_new_acc_clr", dp_acc_clr, 1'b1);
        applyInputs(1'b1, 3'd1, 1'b1, 1'b0);
        checkOutput("abort_new_acc_en", dp_acc_en, 1'b1);
        waitOutValid("abort_new");
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("abort_new_e0", 3'd3, 3'd0, 1'b0);
        applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        checkEmit("abort_new_e1", 3'd1, 3'd1, 1'b1);

`ifdef SOFTMAX_CTRL_PERF_EN
        $display("[TB] perf counter sequence");
        doReset();
        checkOutput("perf_reset", perf_vec_cnt, 16'd0);
        for (int v = 0; v < 3; v++) begin
            applyInputs(1'b1, 3'(v), 1'b1, 1'b0);
            waitOutValid("perf");
            applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        end
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("perf_three", perf_vec_cnt, 16'd3);
        force dut.perf_cnt = 16'hFFFE;
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        release dut.perf_cnt;
        for (int v = 0; v < 2; v++) begin
            applyInputs(1'b1, 3'(v), 1'b1, 1'b0);
            waitOutValid("perf_sat");
            applyInputs(1'b0, 3'd0, 1'b0, 1'b1);
        end
        applyInputs(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("perf_saturate", perf_vec_cnt, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_seq_ctrl.md
SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

Interface
REQ-001 Parameter N_ELEM, default 8: maximum elements per vector (power of two, 2..16).
REQ-002 Parameter ELEM_W, default 3: element width; matches the softmax input bus.
REQ-003 Parameter DP_LAT, default 2: cycles from last accumulate to a stable sum and reciprocal.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: input element valid.
REQ-007 Port in_ready, output, 1: controller accepts an element.
REQ-008 Port in_data, input, ELEM_W: input element.
REQ-009 Port in_last, input, 1: marks the final element of a vector.
REQ-010 Port dp_data, output, ELEM_W: element driven to the adder tree and subtractor array.
REQ-011 Port dp_acc_clr, output, 1: accumulator load-instead-of-add strobe.
REQ-012 Port dp_acc_en, output, 1: accumulator enable.
REQ-013 Port out_valid, output, 1: dp_data in the emit phase is a valid result element.
REQ-014 Port out_ready, input, 1: downstream consumes a result.
REQ-015 Port out_idx, output, $clog2(N_ELEM): index of the emitted element.
REQ-016 Port out_last, output, 1: the emitted element is the last of the vector.
REQ-017 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 FSM SHALL have states IDLE, LOAD, WAIT and EMIT.
REQ-019 IDLE: in_ready=1; accept -> store at index 0, dp_acc_clr=1, dp_acc_en=1, go to LOAD, or to WAIT if in_last.
REQ-020 LOAD: in_ready=1; each accept stores the element at count, pulses dp_acc_en (dp_acc_clr=0) and increments count.
REQ-021 LOAD exit: accepting in_last, or the N_ELEM-th element, goes to WAIT; without in_last, the vector is truncated at N_ELEM.
REQ-022 dp_data SHALL equal in_data in IDLE and LOAD, so the accumulate has zero added latency.
REQ-023 WAIT: in_ready=0, dp_acc_en=0; stay exactly DP_LAT cycles, then go to EMIT.
REQ-024 EMIT: out_valid=1; dp_data=buffer[out_idx]; out_idx starts at 0.
REQ-025 EMIT: a handshake (out_valid & out_ready) advances out_idx; out_last=1 when out_idx equals count-1.
REQ-026 EMIT: the handshake with out_last=1 goes to IDLE; the next vector can be accepted on the following cycle.
REQ-027 When out_valid=1 and out_ready=0, dp_data, out_idx and out_last SHALL hold stable.
REQ-028 in_ready SHALL be 0 in WAIT and EMIT; there is no overlap between vectors.
REQ-029 in_valid=0 in LOAD SHALL stall with no state change.
REQ-030 A single-element vector (in_last in IDLE) SHALL emit exactly one element with out_last=1.

Reset
REQ-031 rst SHALL force IDLE, count=0, out_idx=0, in_ready=1, and 0 on out_valid, out_last, dp_acc_en, dp_acc_clr and busy.
REQ-032 rst in any state, including mid-EMIT, SHALL abort the vector on the next edge; buffer contents are don't-care.

Configuration
REQ-033 With SOFTMAX_CTRL_PERF_EN defined, add output perf_vec_cnt [15:0]: it increments on each final EMIT handshake, saturates at 16'hFFFF and resets to 0.
REQ-034 Without SOFTMAX_CTRL_PERF_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package softmax_pkg SHALL hold the state enum type, the default ELEM_W and N_ELEM constants, and the count width function.
REQ-036 Sub-module softmax_elem_buf SHALL implement the N_ELEM x ELEM_W register buffer: one write port and one combinational read port, with no reset.

Verification
REQ-037 Load 8 elements 1..7,0 back-to-back with no in_last -> exactly 8 dp_acc_en pulses, dp_acc_clr on the first only, 2 WAIT cycles, then 8 emits with dp_data 1..7,0 and out_last on idx 7.
REQ-038 Load 3 elements with in_last on the 3rd -> WAIT, then 3 emits, out_last at idx 2, then IDLE with in_ready=1.
REQ-039 Hold out_ready=0 for 5 cycles during EMIT idx 1 -> dp_data and out_idx stable; resume -> order preserved.
REQ-040 Single element 5 with in_last -> one emit, dp_data=5, out_idx=0, out_last=1.
REQ-041 Assert rst in EMIT at idx 4 -> next cycle in IDLE, out_valid=0, busy=0, in_ready=1; a new 2-element vector then processes correctly.
REQ-042 With SOFTMAX_CTRL_PERF_EN, run 3 vectors -> perf_vec_cnt=3; with perf_vec_cnt preset near saturation, the count holds at 16'hFFFF.
